// File: rtl/sign_detect.sv
// sign_detect: consumer side of the sign-reset handshake.
// Requests a window with sign_en, waits for the controller's low pulse on
// sign_reset, classifies the next N valid signed samples and reports the
// majority sign once per window. All outputs come straight from flops.
module sign_detect #(
    parameter int W   = 8,
    parameter int N   = 16,
    parameter int TMO = 8,
    parameter int CW  = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          sign_reset,
    input  logic          din_valid,
    input  logic [W-1:0]  din,
    output logic          sign_en,
    output logic          busy,
    output logic          sign_valid,
    output logic [1:0]    sign_out,
    output logic [CW-1:0] pos_cnt,
    output logic [CW-1:0] neg_cnt,
    output logic          tmo_err
);

    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_COLLECT = 2'd2,
        S_REPORT  = 2'd3
    } state_t;

    // Majority encoding: 01 positive, 11 negative, 00 tie (unsigned compare).
    function automatic logic [1:0] majority(input logic [CW-1:0] pos, input logic [CW-1:0] neg);
        logic [1:0] res;
        if (pos > neg) begin
            res = 2'b01;
        end else if (neg > pos) begin
            res = 2'b11;
        end else begin
            res = 2'b00;
        end
        return res;
    endfunction

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [CW-1:0] smp_q, smp_d;
    logic [CW-1:0] pos_q, pos_d;
    logic [CW-1:0] neg_q, neg_d;
    logic          err_q, err_d;
    logic [1:0]    sout_q, sout_d;
    logic          sign_en_q, sign_en_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;

    // Next-state, counter updates and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        smp_d   = smp_q;
        pos_d   = pos_q;
        neg_d   = neg_q;
        err_d   = err_q;
        sout_d  = sout_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    tmo_d   = TW'(TMO);
                    state_d = S_ARM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARM: begin
                if (!sign_reset) begin
                    // Window opens; the sample in this cycle is not counted.
                    pos_d   = {CW{1'b0}};
                    neg_d   = {CW{1'b0}};
                    smp_d   = {CW{1'b0}};
                    state_d = S_COLLECT;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                    if (tmo_q <= TW'(1)) begin
                        // Timed out: counts from the last window stay visible.
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ARM;
                    end
                end
            end
            S_COLLECT: begin
                if (!sign_reset) begin
                    // Controller restarted the window; drop this sample.
                    pos_d = {CW{1'b0}};
                    neg_d = {CW{1'b0}};
                    smp_d = {CW{1'b0}};
                end else if (din_valid) begin
                    smp_d = smp_q + CW'(1);
                    if (din[W-1]) begin
                        neg_d = neg_q + CW'(1);
                    end else if (din != {W{1'b0}}) begin
                        pos_d = pos_q + CW'(1);
                    end else begin
                        pos_d = pos_q;
                    end
                    if (smp_d == CW'(N)) begin
                        sout_d  = majority(pos_d, neg_d);
                        state_d = S_REPORT;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_REPORT: begin
                // start is deliberately not looked at here.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        sign_en_d = (state_d == S_ARM);
        busy_d    = (state_d == S_ARM) || (state_d == S_COLLECT);
        valid_d   = (state_d == S_REPORT);
    end

    // State, counters and output registers; rst clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tmo_q     <= {TW{1'b0}};
            smp_q     <= {CW{1'b0}};
            pos_q     <= {CW{1'b0}};
            neg_q     <= {CW{1'b0}};
            err_q     <= 1'b0;
            sout_q    <= 2'b00;
            sign_en_q <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            smp_q     <= smp_d;
            pos_q     <= pos_d;
            neg_q     <= neg_d;
            err_q     <= err_d;
            sout_q    <= sout_d;
            sign_en_q <= sign_en_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
        end
    end

    assign sign_en    = sign_en_q;
    assign busy       = busy_q;
    assign sign_valid = valid_q;
    assign sign_out   = sout_q;
    assign pos_cnt    = pos_q;
    assign neg_cnt    = neg_q;
    assign tmo_err    = err_q;

endmodule

// File: tb/tb_sign_detect.sv
// Directed testbench for sign_detect: one N=16/TMO=8 instance and one N=1
// instance sharing clock, reset and the controller/sample inputs.
module tb_sign_detect;

    localparam int W   = 8;
    localparam int N   = 16;
    localparam int TMO = 8;
    localparam int CW  = $clog2(N + 1);
    localparam int CW1 = $clog2(1 + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           start1;
    logic           sign_reset;
    logic           din_valid;
    logic [W-1:0]   din;

    logic           sign_en, busy, sign_valid, tmo_err;
    logic [1:0]     sign_out;
    logic [CW-1:0]  pos_cnt, neg_cnt;

    logic           sign_en1, busy1, sign_valid1, tmo_err1;
    logic [1:0]     sign_out1;
    logic [CW1-1:0] pos_cnt1, neg_cnt1;

    int checks   = 0;
    int failures = 0;

    sign_detect #(.W(W), .N(N), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .sign_reset(sign_reset),
        .din_valid(din_valid), .din(din), .sign_en(sign_en), .busy(busy),
        .sign_valid(sign_valid), .sign_out(sign_out), .pos_cnt(pos_cnt),
        .neg_cnt(neg_cnt), .tmo_err(tmo_err)
    );

    sign_detect #(.W(W), .N(1), .TMO(TMO)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sign_reset(sign_reset),
        .din_valid(din_valid), .din(din), .sign_en(sign_en1), .busy(busy1),
        .sign_valid(sign_valid1), .sign_out(sign_out1), .pos_cnt(pos_cnt1),
        .neg_cnt(neg_cnt1), .tmo_err(tmo_err1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic v, input logic [W-1:0] d);
        din_valid = v;
        din       = d;
        tick();
    endtask

    int cnt;
    int vcnt;

    initial begin
        rst = 1'b1; start = 1'b0; start1 = 1'b0; sign_reset = 1'b1;
        din_valid = 1'b0; din = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_sign_en", sign_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", sign_valid, 1'b0);
        chk("rst_sign_out", sign_out, 2'b00);
        chk("rst_pos", pos_cnt, 0);
        chk("rst_neg", neg_cnt, 0);
        chk("rst_tmo_err", tmo_err, 1'b0);
        chk("rst_n1_valid", sign_valid1, 1'b0);
        rst = 1'b0;
        tick();

        // Basic window: 10 x +5, 4 x -3, 2 x 0
        start = 1'b1; tick(); start = 1'b0;
        chk("basic_arm_en", sign_en, 1'b1);
        chk("basic_arm_busy", busy, 1'b1);
        tick();
        chk("basic_arm_hold", sign_en, 1'b1);
        sign_reset = 1'b0; din_valid = 1'b1; din = 8'd5; tick(); sign_reset = 1'b1;
        chk("basic_col_en", sign_en, 1'b0);
        chk("basic_col_busy", busy, 1'b1);
        chk("basic_first_dropped", pos_cnt, 0);
        for (int i = 0; i < 16; i++) begin
            send(1'b1, (i < 10) ? 8'd5 : ((i < 14) ? 8'hFD : 8'h00));
            if (i == 14) chk("basic_no_early_valid", sign_valid, 1'b0);
        end
        chk("basic_valid", sign_valid, 1'b1);
        chk("basic_sign_out", sign_out, 2'b01);
        chk("basic_pos", pos_cnt, 10);
        chk("basic_neg", neg_cnt, 4);
        send(1'b0, 8'h00);
        chk("basic_valid_1cyc", sign_valid, 1'b0);
        chk("basic_idle_busy", busy, 1'b0);
        chk("basic_hold_out", sign_out, 2'b01);

        // Tie with gaps: alternating -1 / +1 separated by idle cycles
        start = 1'b1; tick(); start = 1'b0;
        sign_reset = 1'b0; tick(); sign_reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(1'b0, 8'h55);
            send(1'b1, i[0] ? 8'h01 : 8'hFF);
            if (i == 14) chk("tie_no_early_valid", sign_valid, 1'b0);
        end
        chk("tie_valid", sign_valid, 1'b1);
        chk("tie_sign_out", sign_out, 2'b00);
        chk("tie_pos", pos_cnt, 8);
        chk("tie_neg", neg_cnt, 8);
        send(1'b0, 8'h00);
        chk("tie_valid_1cyc", sign_valid, 1'b0);

        // Timeout: sign_reset never goes low
        start = 1'b1; tick(); start = 1'b0;
        cnt = 0;
        while (sign_en && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("tmo_en_cycles", cnt, 8);
        chk("tmo_err_set", tmo_err, 1'b1);
        chk("tmo_busy", busy, 1'b0);
        chk("tmo_pos_kept", pos_cnt, 8);
        chk("tmo_neg_kept", neg_cnt, 8);
        tick();
        chk("tmo_err_sticky", tmo_err, 1'b1);
        start = 1'b1; tick(); start = 1'b0;
        chk("tmo_err_cleared", tmo_err, 1'b0);
        chk("tmo_rearm_en", sign_en, 1'b1);

        // Restart mid-window, then 16 x -128
        sign_reset = 1'b0; tick(); sign_reset = 1'b1;
        for (int i = 0; i < 7; i++) send(1'b1, 8'd5);
        chk("rs_pos7", pos_cnt, 7);
        sign_reset = 1'b0; din_valid = 1'b1; din = 8'd5; tick(); sign_reset = 1'b1;
        chk("rs_pos_clr", pos_cnt, 0);
        chk("rs_neg_clr", neg_cnt, 0);
        chk("rs_busy", busy, 1'b1);
        for (int i = 0; i < 16; i++) begin
            send(1'b1, 8'h80);
            if (i == 14) chk("rs_no_early_valid", sign_valid, 1'b0);
        end
        chk("rs_valid", sign_valid, 1'b1);
        chk("rs_sign_out", sign_out, 2'b11);
        chk("rs_neg", neg_cnt, 16);
        chk("rs_pos", pos_cnt, 0);
        send(1'b0, 8'h00);

        // N=1 instance: +127 then -128
        start1 = 1'b1; tick(); start1 = 1'b0;
        chk("n1_arm_en", sign_en1, 1'b1);
        sign_reset = 1'b0; tick(); sign_reset = 1'b1;
        send(1'b1, 8'h7F);
        chk("n1_valid", sign_valid1, 1'b1);
        chk("n1_pos_out", sign_out1, 2'b01);
        chk("n1_pos_cnt", pos_cnt1, 1);
        send(1'b0, 8'h00);
        chk("n1_valid_1cyc", sign_valid1, 1'b0);
        chk("n1_hold_out", sign_out1, 2'b01);
        chk("n1_big_idle", busy, 1'b0);
        start1 = 1'b1; tick(); start1 = 1'b0;
        sign_reset = 1'b0; tick(); sign_reset = 1'b1;
        send(1'b1, 8'h80);
        chk("n1_neg_valid", sign_valid1, 1'b1);
        chk("n1_neg_out", sign_out1, 2'b11);
        chk("n1_neg_cnt", neg_cnt1, 1);
        chk("n1_neg_pos0", pos_cnt1, 0);
        send(1'b0, 8'h00);

        // Asynchronous reset mid-COLLECT
        start = 1'b1; tick(); start = 1'b0;
        sign_reset = 1'b0; tick(); sign_reset = 1'b1;
        for (int i = 0; i < 5; i++) send(1'b1, 8'd5);
        chk("ar_pre_busy", busy, 1'b1);
        chk("ar_pre_pos", pos_cnt, 5);
        #2 rst = 1'b1;
        #1;
        chk("ar_busy", busy, 1'b0);
        chk("ar_sign_en", sign_en, 1'b0);
        chk("ar_sign_out", sign_out, 2'b00);
        chk("ar_pos", pos_cnt, 0);
        chk("ar_neg", neg_cnt, 0);
        chk("ar_valid", sign_valid, 1'b0);
        chk("ar_tmo_err", tmo_err, 1'b0);
        tick();
        rst = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            send(1'b1, 8'd5);
            if (sign_valid) vcnt++;
        end
        chk("ar_no_report", vcnt, 0);
        chk("ar_idle_busy", busy, 1'b0);
        chk("ar_idle_pos", pos_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
